// File: rtl/lif_neuron_unit.sv
// rtl/lif_neuron_unit.sv - leaky integrate-and-fire neuron fed by one PE; optional LIF_SPIKE_COUNT_EN adds o_spike_count
module lif_neuron_unit #(
  parameter int IN_W          = 8,
  parameter int ADDR_W        = 4,
  parameter int VMEM_W        = 12,
  parameter int THRESHOLD     = 100,
  parameter int V_RESET       = 0,
  parameter int LEAK_SHIFT    = 3,
  parameter int REFRACT_STEPS = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_spike_done,
  input  logic [IN_W-1:0]   i_pe_out,
  input  logic [ADDR_W-1:0] i_pe_addr,
  input  logic              i_spike_ready,
  output logic              o_spike_valid,
  output logic [ADDR_W-1:0] o_spike_addr,
  output logic [VMEM_W-1:0] o_v_mem,
`ifdef LIF_SPIKE_COUNT_EN
  output logic [15:0]       o_spike_count,
`endif
  output logic              o_overflow
);

  localparam int EXT_W = VMEM_W + 2;
  localparam int RC_W  = (REFRACT_STEPS < 1) ? 1 : $clog2(REFRACT_STEPS + 1);
  localparam int MAX_I = (1 << (VMEM_W - 1)) - 1;
  localparam int MIN_I = -(1 << (VMEM_W - 1));
  localparam logic signed [EXT_W-1:0] P_MAX = EXT_W'(MAX_I);
  localparam logic signed [EXT_W-1:0] P_MIN = EXT_W'(MIN_I);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_FIRE} state_t;

  state_t                    r_state;
  logic signed [VMEM_W-1:0]  r_v_mem;
  logic                      r_spike_valid;
  logic [ADDR_W-1:0]         r_spike_addr;
  logic                      r_overflow;
  logic [RC_W-1:0]           r_refract_cnt;
  logic                      r_spike_done_q;
  logic signed [IN_W-1:0]    r_cur_in;
  logic [ADDR_W-1:0]         r_cur_addr;
  logic                      r_pend;
  logic signed [IN_W-1:0]    r_pend_in;
  logic [ADDR_W-1:0]         r_pend_addr;

  logic                      w_evt;
  logic                      w_hs;
  logic                      w_take_pend;
  logic                      w_buf_evt;
  logic signed [EXT_W-1:0]   w_v_ext;
  logic signed [EXT_W-1:0]   w_leak;
  logic signed [EXT_W-1:0]   w_sum;
  logic signed [VMEM_W-1:0]  w_v_next;
  logic                      w_fire;

  assign w_evt       = i_spike_done & ~r_spike_done_q;
  assign w_hs        = (r_state == S_FIRE) & r_spike_valid & i_spike_ready;
  assign w_take_pend = r_pend & ((r_state == S_IDLE) | w_hs);
  // Only an event seen in IDLE with nothing queued is captured directly.
  assign w_buf_evt   = w_evt & ~((r_state == S_IDLE) & ~r_pend);

  assign w_v_ext = EXT_W'(r_v_mem);
  assign w_leak  = (LEAK_SHIFT == 0) ? '0 : (w_v_ext >>> LEAK_SHIFT);
  assign w_sum   = w_v_ext - w_leak + EXT_W'(r_cur_in);

  always_comb begin
    w_v_next = w_sum[VMEM_W-1:0];
    if (w_sum > P_MAX)      w_v_next = VMEM_W'(MAX_I);
    else if (w_sum < P_MIN) w_v_next = VMEM_W'(MIN_I);
  end

  assign w_fire = int'(w_v_next) >= THRESHOLD;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_v_mem        <= VMEM_W'(V_RESET);
      r_spike_valid  <= 1'b0;
      r_spike_addr   <= '0;
      r_overflow     <= 1'b0;
      r_refract_cnt  <= '0;
      r_spike_done_q <= 1'b0;
      r_cur_in       <= '0;
      r_cur_addr     <= '0;
      r_pend         <= 1'b0;
      r_pend_in      <= '0;
      r_pend_addr    <= '0;
    end else begin
      r_spike_done_q <= i_spike_done;
      if (w_take_pend) r_pend <= 1'b0;
      if (w_buf_evt) begin
        if (!r_pend || w_take_pend) begin
          r_pend      <= 1'b1;
          r_pend_in   <= i_pe_out;
          r_pend_addr <= i_pe_addr;
        end else begin
          r_overflow <= 1'b1;
        end
      end
      case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_cur_in   <= r_pend_in;
            r_cur_addr <= r_pend_addr;
            r_state    <= S_UPDATE;
          end else if (w_evt) begin
            r_cur_in   <= i_pe_out;
            r_cur_addr <= i_pe_addr;
            r_state    <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          if (r_refract_cnt != '0) begin
            r_refract_cnt <= r_refract_cnt - RC_W'(1);
            r_v_mem       <= VMEM_W'(V_RESET);
            r_state       <= S_IDLE;
          end else if (w_fire) begin
            r_v_mem       <= VMEM_W'(V_RESET);
            r_refract_cnt <= RC_W'(REFRACT_STEPS);
            r_spike_valid <= 1'b1;
            r_spike_addr  <= r_cur_addr;
            r_state       <= S_FIRE;
          end else begin
            r_v_mem <= w_v_next;
            r_state <= S_IDLE;
          end
        end
        S_FIRE: begin
          if (w_hs) begin
            r_spike_valid <= 1'b0;
            if (r_pend) begin
              r_cur_in   <= r_pend_in;
              r_cur_addr <= r_pend_addr;
              r_state    <= S_UPDATE;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] r_spike_count;

  always_ff @(posedge i_clock) begin
    if (i_reset)                           r_spike_count <= '0;
    else if (w_hs && r_spike_count != '1)  r_spike_count <= r_spike_count + 16'd1;
  end

  assign o_spike_count = r_spike_count;
`endif

  assign o_spike_valid = r_spike_valid;
  assign o_spike_addr  = r_spike_addr;
  assign o_v_mem       = r_v_mem;
  assign o_overflow    = r_overflow;

endmodule

// File: tb/tb_lif_neuron_unit.sv
// tb/tb_lif_neuron_unit.sv - directed bench for lif_neuron_unit (default and saturating instances)
module tb_lif_neuron_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        done_a, done_b;
  logic [7:0]  in_a, in_b;
  logic [3:0]  addr_a, addr_b;
  logic        ready_a;
  logic        valid_a, valid_b;
  logic [3:0]  saddr_a, saddr_b;
  logic [11:0] v_a, v_b;
  logic        ovf_a, ovf_b;
`ifdef LIF_SPIKE_COUNT_EN
  logic [15:0] cnt_a, cnt_b;
`endif
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lif_neuron_unit u_dut (
    .i_clock(clk), .i_reset(reset), .i_spike_done(done_a), .i_pe_out(in_a),
    .i_pe_addr(addr_a), .i_spike_ready(ready_a), .o_spike_valid(valid_a),
    .o_spike_addr(saddr_a), .o_v_mem(v_a),
`ifdef LIF_SPIKE_COUNT_EN
    .o_spike_count(cnt_a),
`endif
    .o_overflow(ovf_a)
  );

  lif_neuron_unit #(.THRESHOLD(2047), .LEAK_SHIFT(0)) u_sat (
    .i_clock(clk), .i_reset(reset), .i_spike_done(done_b), .i_pe_out(in_b),
    .i_pe_addr(addr_b), .i_spike_ready(1'b1), .o_spike_valid(valid_b),
    .o_spike_addr(saddr_b), .o_v_mem(v_b),
`ifdef LIF_SPIKE_COUNT_EN
    .o_spike_count(cnt_b),
`endif
    .o_overflow(ovf_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One-cycle spike_done pulse; returns just after the edge that sees the event.
  task automatic pulse(input bit sel, input int val, input int addr);
    @(negedge clk);
    if (!sel) begin in_a = 8'(val); addr_a = 4'(addr); done_a = 1'b1; end
    else      begin in_b = 8'(val); addr_b = 4'(addr); done_b = 1'b1; end
    @(negedge clk);
    done_a = 1'b0;
    done_b = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; done_a = 1'b0; done_b = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; done_a = 1'b0; done_b = 1'b0;
    in_a = '0; in_b = '0; addr_a = '0; addr_b = '0; ready_a = 1'b1;
    do_reset();
    chk("rst_v", int'($signed(v_a)), 0);
    chk("rst_valid", int'(valid_a), 0);
    chk("rst_addr", int'(saddr_a), 0);
    chk("rst_ovf", int'(ovf_a), 0);

    pulse(0, 40, 1); @(negedge clk); chk("int1_v", int'($signed(v_a)), 40);
    pulse(0, 40, 1); @(negedge clk); chk("int2_v", int'($signed(v_a)), 75);
    pulse(0, 40, 1); @(negedge clk);
    chk("fire_valid", int'(valid_a), 1);
    chk("fire_addr", int'(saddr_a), 1);
    chk("fire_v", int'($signed(v_a)), 0);
    @(negedge clk); chk("fire_pulse_end", int'(valid_a), 0);

    pulse(0, 40, 1); @(negedge clk);
    chk("refr1_v", int'($signed(v_a)), 0);
    chk("refr1_valid", int'(valid_a), 0);
    pulse(0, 40, 1); @(negedge clk); chk("refr2_v", int'($signed(v_a)), 0);
    pulse(0, 40, 1); @(negedge clk); chk("refr_done_v", int'($signed(v_a)), 40);

    do_reset();
    @(negedge clk); in_a = 8'd10; done_a = 1'b1;
    repeat (20) @(negedge clk);
    done_a = 1'b0;
    repeat (3) @(negedge clk);
    chk("held_v", int'($signed(v_a)), 10);

    for (int k = 1; k <= 16; k++) begin
      pulse(1, 127, 5); @(negedge clk);
      chk($sformatf("sat_up%0d", k), int'($signed(v_b)), 127 * k);
    end
    pulse(1, 127, 5); @(negedge clk);
    chk("sat_fire_valid", int'(valid_b), 1);
    chk("sat_fire_addr", int'(saddr_b), 5);
    chk("sat_fire_v", int'($signed(v_b)), 0);
    @(negedge clk);
    for (int k = 1; k <= 22; k++) begin
      pulse(1, -128, 5); @(negedge clk);
      if (k == 2)  chk("sat_refr_v", int'($signed(v_b)), 0);
      if (k == 3)  chk("sat_neg1_v", int'($signed(v_b)), -128);
      if (k == 18) chk("sat_neg16_v", int'($signed(v_b)), -2048);
    end
    chk("sat_neg_floor", int'($signed(v_b)), -2048);
    chk("sat_neg_novalid", int'(valid_b), 0);

    do_reset();
    ready_a = 1'b0;
    pulse(0, 127, 3); @(negedge clk);
    chk("bp_valid", int'(valid_a), 1);
    chk("bp_addr", int'(saddr_a), 3);
    pulse(0, 20, 4);
    chk("bp_buffered_ovf", int'(ovf_a), 0);
    pulse(0, 20, 4);
    chk("bp_drop_ovf", int'(ovf_a), 1);
    chk("bp_hold_valid", int'(valid_a), 1);
    chk("bp_hold_addr", int'(saddr_a), 3);
    ready_a = 1'b1;
    @(negedge clk); chk("bp_hs_valid", int'(valid_a), 0);
    repeat (2) @(negedge clk);
    pulse(0, 30, 6); @(negedge clk); chk("bp_refr_v", int'($signed(v_a)), 0);
    pulse(0, 30, 6); @(negedge clk); chk("bp_after_v", int'($signed(v_a)), 30);
    chk("bp_ovf_sticky", int'(ovf_a), 1);

    ready_a = 1'b0;
    pulse(0, 127, 7); @(negedge clk);
    chk("rf_valid", int'(valid_a), 1);
    chk("rf_addr", int'(saddr_a), 7);
    reset = 1'b1;
    @(negedge clk);
    chk("rf_valid_clr", int'(valid_a), 0);
    chk("rf_v_clr", int'($signed(v_a)), 0);
    chk("rf_ovf_clr", int'(ovf_a), 0);
    chk("rf_addr_clr", int'(saddr_a), 0);
    reset = 1'b0;
    ready_a = 1'b1;
`ifdef LIF_SPIKE_COUNT_EN
    chk("cnt_rst", int'(cnt_a), 0);
`endif
    pulse(0, 40, 1); @(negedge clk); chk("rf_idle_v", int'($signed(v_a)), 40);
`ifdef LIF_SPIKE_COUNT_EN
    for (int k = 0; k < 3; k++) begin
      pulse(0, 127, 2); repeat (2) @(negedge clk);
      pulse(0, 0, 2); pulse(0, 0, 2); @(negedge clk);
    end
    chk("cnt_three", int'(cnt_a), 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/lif_neuron_unit.md
Name: lif_neuron_unit

Overview:
- Downstream consumer of the PE accumulator. At each timestep boundary, signalled by spike_done, it latches the PE's 8-bit synaptic sum (pe_out) and PE index (pe_addr).
- Applies leaky-integrate-and-fire dynamics to a membrane potential and emits an address-tagged output spike over a valid/ready handshake toward the spike router.
- Single neuron per instance; one instance per PE.

Parameters:
- IN_W, 8, width of pe_out (two's-complement signed).
- ADDR_W, 4, width of pe_addr / spike_addr.
- VMEM_W, 12, membrane potential width (signed).
- THRESHOLD, 100, fire when v_next >= THRESHOLD (signed compare).
- V_RESET, 0, potential loaded after a fire.
- LEAK_SHIFT, 3, leak = v >>> LEAK_SHIFT; 0 disables leak entirely.
- REFRACT_STEPS, 2, timestep events ignored after a fire.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- spike_done  in  1  PE timestep-complete level; its rising edge is a timestep event.
- pe_out  in  IN_W  PE accumulated current, signed.
- pe_addr  in  ADDR_W  PE index.
- spike_valid  out  1  output spike pending.
- spike_ready  in  1  consumer accepts spike.
- spike_addr  out  ADDR_W  index of firing neuron.
- v_mem  out  VMEM_W  current membrane potential (registered).
- overflow  out  1  sticky: a timestep event was dropped.
- spike_count  out  16  only with LIF_SPIKE_COUNT_EN.

Behaviour:
- Reset (sync, active-high) takes priority over everything, including mid-handshake:
  - State goes to IDLE.
  - v_mem=V_RESET, spike_valid=0, spike_addr=0, overflow=0.
  - Refractory counter=0, pending flag=0, spike_done_q=0, spike_count=0.
- Event definition: evt = spike_done & ~spike_done_q, where spike_done_q is a one-cycle delayed copy. spike_done held high produces exactly one event.
- FSM states: IDLE, UPDATE, FIRE.
  - IDLE: on evt, capture pe_out and pe_addr into cur_in and cur_addr, then go to UPDATE.
  - UPDATE (one cycle):
    - If refract_cnt>0: decrement it, hold v_mem=V_RESET, go to IDLE.
    - Otherwise compute v_next = sat(v_mem - (v_mem >>> LEAK_SHIFT) + sext(cur_in)). Use VMEM_W+2-bit intermediate precision, then saturate to [-2^(VMEM_W-1), 2^(VMEM_W-1)-1].
    - If v_next >= THRESHOLD: v_mem=V_RESET, refract_cnt=REFRACT_STEPS, spike_valid=1, spike_addr=cur_addr, go to FIRE.
    - Else: v_mem=v_next, go to IDLE.
  - FIRE: hold spike_valid, spike_addr stable until spike_valid&spike_ready.
    - On handshake: spike_valid=0.
    - Then go to UPDATE if pending (load cur_in and cur_addr from the pending buffer, clear pending); otherwise go to IDLE.
- Latency: evt seen at edge N → v_mem updated at edge N+1 → spike_valid high after edge N+1. spike_ready high in that cycle completes the transfer at edge N+2.
- Events outside IDLE (in UPDATE or FIRE):
  - First such event is stored in a one-deep pending buffer (pe_out, pe_addr).
  - If the buffer is already full, the event is dropped and overflow=1 (sticky until reset).
- Pending in IDLE: when pending is set and state is IDLE, go straight to UPDATE using the buffered values. An event arriving in that same cycle goes into the just-freed buffer.
- Refractory events still consume an UPDATE cycle, but input is discarded.
- LEAK_SHIFT=0: no leak term (pure integrate-and-fire).

Optional Feature:
- Macro: LIF_SPIKE_COUNT_EN.
- Defined: port spike_count[15:0] exists. It increments by 1 on each completed spike handshake and saturates at 0xFFFF. Cleared by reset.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Defaults; spike_ready=1; three events with pe_out=40 → v_mem 40, 75, then fire. spike_valid pulses for 1 cycle with spike_addr=pe_addr (0x1), and v_mem=0.
- Refractory: after the fire above, two more events with pe_out=40 → v_mem stays 0, no spike. Third event → v_mem=40.
- spike_done held high 20 cycles, pe_out=10 → exactly one event, v_mem=10.
- THRESHOLD=2047, LEAK_SHIFT=0, 17 events of pe_out=127 → v_mem 127…2032. 17th event saturates to 2047 and fires. pe_out=-128 ×20 from 0 → v_mem=-2048 saturated, no wrap.
- Backpressure: spike_ready=0, force a fire, then two more events → first is buffered, second drops and overflow=1. Raise spike_ready → handshake, then the buffered event is processed. overflow stays 1.
- Reset asserted while in FIRE with spike_valid=1 → next cycle: spike_valid=0, v_mem=0, overflow=0, state IDLE. With LIF_SPIKE_COUNT_EN: spike_count=0, and the count after 3 accepted spikes is 3.
